// File: rtl/ifetch_miss_unit_pkg.sv
// +--------------------------------------------------------------------------+
// | ifetch_miss_unit_pkg: shared L1I geometry, line/thread types and the     |
// | miss-entry record used by the instruction-side miss handler.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif
`ifndef L1I_WAYS
`define L1I_WAYS 4
`endif

`default_nettype none

package ifetch_miss_unit_pkg;

  localparam int THREADS_PER_CORE   = `THREADS_PER_CORE;
  localparam int L1I_WAYS           = `L1I_WAYS;
  localparam int L1I_SETS           = 64;
  localparam int CACHE_LINE_BITS    = 512;
  localparam int CACHE_LINE_INDEX_W = 26;
  localparam int L1I_SET_W          = $clog2(L1I_SETS);
  localparam int L1I_TAG_W          = CACHE_LINE_INDEX_W - L1I_SET_W;
  localparam int L1I_WAY_W          = $clog2(L1I_WAYS);
  localparam int THREAD_IDX_W       = $clog2(THREADS_PER_CORE);

  typedef logic [CACHE_LINE_INDEX_W-1:0] cache_line_index_t;
  typedef logic [L1I_SET_W-1:0]          l1i_set_idx_t;
  typedef logic [L1I_TAG_W-1:0]          l1i_tag_t;
  typedef logic [L1I_WAY_W-1:0]          l1i_way_idx_t;
  typedef logic [CACHE_LINE_BITS-1:0]    cache_line_data_t;
  typedef logic [THREAD_IDX_W-1:0]       local_thread_idx_t;

  typedef struct packed {
    logic                        valid;
    logic                        issued;
    cache_line_index_t           addr;
    logic [THREADS_PER_CORE-1:0] waiting;
  } ifetch_miss_entry_t;

  function automatic l1i_set_idx_t line_set(input cache_line_index_t addr);
    return addr[L1I_SET_W-1:0];
  endfunction

  function automatic l1i_tag_t line_tag(input cache_line_index_t addr);
    return addr[CACHE_LINE_INDEX_W-1:L1I_SET_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_miss_unit_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | ifetch_miss_unit_rr_arbiter: round-robin pick among requesters; the      |
// | pointer moves past the index the caller reports as accepted.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ifetch_miss_unit_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request_i,
  input  logic               advance_i,
  input  logic [IDX_W-1:0]   advance_idx_i,
  output logic               grant_valid_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = IDX_W'((int'(advance_idx_i) + 1) % NUM_REQ);
  end

  // Scan from the farthest offset down so the requester nearest the pointer wins.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    cand          = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (request_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_miss_unit.sv
// +--------------------------------------------------------------------------+
// | ifetch_miss_unit: icache miss coalescing, L2 line requests and the       |
// | victim-tag-data fill pipeline. Optional IFETCH_MISS_PERF_EN adds perf    |
// | event outputs. Rev 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module ifetch_miss_unit
  import ifetch_miss_unit_pkg::*;
#(
  parameter int NUM_ENTRIES = THREADS_PER_CORE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ifd_cache_miss,
  input  cache_line_index_t           ifd_cache_miss_paddr,
  input  local_thread_idx_t           ifd_cache_miss_thread_idx,
  output logic                        ifm_request_valid,
  output cache_line_index_t           ifm_request_paddr,
  output local_thread_idx_t           ifm_request_entry,
  input  logic                        l2_request_ready,
  input  logic                        l2_response_valid,
  input  local_thread_idx_t           l2_response_entry,
  input  cache_line_data_t            l2_response_data,
  output logic                        ifm_lru_fill_en,
  output l1i_set_idx_t                ifm_lru_fill_set,
  input  l1i_way_idx_t                ift_fill_lru,
  output logic [L1I_WAYS-1:0]         l2i_itag_update_en,
  output l1i_set_idx_t                l2i_itag_update_set,
  output l1i_tag_t                    l2i_itag_update_tag,
  output logic                        l2i_idata_update_en,
  output l1i_way_idx_t                l2i_idata_update_way,
  output l1i_set_idx_t                l2i_idata_update_set,
  output cache_line_data_t            l2i_idata_update_data,
  output logic [THREADS_PER_CORE-1:0] ifm_wake_bitmap,
  output logic                        ifm_perf_coalesced,
  output logic                        ifm_perf_queue_busy
);

  if (NUM_ENTRIES != THREADS_PER_CORE) begin : g_bad_entries
    $error("ifetch_miss_unit: NUM_ENTRIES must equal THREADS_PER_CORE");
  end

  ifetch_miss_entry_t          entry_q [NUM_ENTRIES];
  ifetch_miss_entry_t          entry_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]      hit_vec;
  logic [NUM_ENTRIES-1:0]      pending;
  logic [THREADS_PER_CORE-1:0] thread_oh;
  logic                        miss_hit;
  logic                        r0_merge;
  logic                        request_fire;
  logic                        arb_valid;
  local_thread_idx_t           arb_idx;
  logic                        hold_q;
  local_thread_idx_t           hold_entry_q;

  // R1 / R2 fill pipeline registers
  logic                        s1_valid_q;
  l1i_set_idx_t                s1_set_q;
  l1i_tag_t                    s1_tag_q;
  cache_line_data_t            s1_data_q;
  logic [THREADS_PER_CORE-1:0] s1_waiting_q;
  logic                        s2_valid_q;
  l1i_way_idx_t                s2_way_q;
  l1i_set_idx_t                s2_set_q;
  cache_line_data_t            s2_data_q;
  logic [THREADS_PER_CORE-1:0] s2_waiting_q;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cam
    assign hit_vec[g] = entry_q[g].valid && (entry_q[g].addr == ifd_cache_miss_paddr);
    assign pending[g] = entry_q[g].valid && !entry_q[g].issued;
  end

  assign thread_oh = THREADS_PER_CORE'(1) << ifd_cache_miss_thread_idx;
  assign miss_hit  = ifd_cache_miss && (|hit_vec);
  // A hit on the entry being freed this cycle must ride along with the fill.
  assign r0_merge  = miss_hit && l2_response_valid && hit_vec[l2_response_entry];

  ifetch_miss_unit_rr_arbiter #(
    .NUM_REQ (NUM_ENTRIES)
  ) u_arb (
    .clk           (clk),
    .reset         (reset),
    .request_i     (pending),
    .advance_i     (request_fire),
    .advance_idx_i (ifm_request_entry),
    .grant_valid_o (arb_valid),
    .grant_idx_o   (arb_idx)
  );

  // Once presented, a request is pinned until L2 takes it.
  assign ifm_request_valid = hold_q || arb_valid;
  assign ifm_request_entry = hold_q ? hold_entry_q : arb_idx;
  assign ifm_request_paddr = entry_q[ifm_request_entry].addr;
  assign request_fire      = ifm_request_valid && l2_request_ready;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) entry_d[i] = entry_q[i];
    if (request_fire) entry_d[ifm_request_entry].issued = 1'b1;
    if (l2_response_valid) entry_d[l2_response_entry] = '0;
    if (ifd_cache_miss) begin
      if (miss_hit) begin
        if (!r0_merge) begin
          for (int i = 0; i < NUM_ENTRIES; i++)
            if (hit_vec[i]) entry_d[i].waiting = entry_q[i].waiting | thread_oh;
        end
      end else begin
        entry_d[ifd_cache_miss_thread_idx] = '{valid: 1'b1, issued: 1'b0,
                                               addr: ifd_cache_miss_paddr,
                                               waiting: thread_oh};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
      hold_q       <= 1'b0;
      hold_entry_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_set_q     <= '0;
      s1_tag_q     <= '0;
      s1_data_q    <= '0;
      s1_waiting_q <= '0;
      s2_valid_q   <= 1'b0;
      s2_way_q     <= '0;
      s2_set_q     <= '0;
      s2_data_q    <= '0;
      s2_waiting_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= entry_d[i];
      hold_q       <= ifm_request_valid && !l2_request_ready;
      hold_entry_q <= ifm_request_entry;
      s1_valid_q   <= l2_response_valid;
      s1_waiting_q <= '0;
      if (l2_response_valid) begin
        s1_set_q     <= line_set(entry_q[l2_response_entry].addr);
        s1_tag_q     <= line_tag(entry_q[l2_response_entry].addr);
        s1_data_q    <= l2_response_data;
        s1_waiting_q <= entry_q[l2_response_entry].waiting | (r0_merge ? thread_oh : '0);
      end
      s2_valid_q   <= s1_valid_q;
      s2_waiting_q <= s1_waiting_q;
      if (s1_valid_q) begin
        s2_way_q  <= ift_fill_lru;
        s2_set_q  <= s1_set_q;
        s2_data_q <= s1_data_q;
      end
    end
  end

  assign ifm_lru_fill_en       = l2_response_valid;
  assign ifm_lru_fill_set      = line_set(entry_q[l2_response_entry].addr);
  assign l2i_itag_update_en    = s1_valid_q ? (L1I_WAYS'(1) << ift_fill_lru) : '0;
  assign l2i_itag_update_set   = s1_set_q;
  assign l2i_itag_update_tag   = s1_tag_q;
  assign l2i_idata_update_en   = s2_valid_q;
  assign l2i_idata_update_way  = s2_way_q;
  assign l2i_idata_update_set  = s2_set_q;
  assign l2i_idata_update_data = s2_data_q;
  assign ifm_wake_bitmap       = s2_waiting_q;

`ifdef IFETCH_MISS_PERF_EN
  assign ifm_perf_coalesced  = miss_hit;
  assign ifm_perf_queue_busy = ifm_request_valid && !l2_request_ready;
`else
  assign ifm_perf_coalesced  = 1'b0;
  assign ifm_perf_queue_busy = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ifd_cache_miss && !miss_hit)
        assert (!entry_q[ifd_cache_miss_thread_idx].valid);
      if (l2_response_valid)
        assert (entry_q[l2_response_entry].valid && entry_q[l2_response_entry].issued);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch_miss_unit.sv
// +--------------------------------------------------------------------------+
// | tb_ifetch_miss_unit: directed scenarios for the ifetch miss unit with    |
// | hand-computed expectations. Rev 1.0                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ifetch_miss_unit;
  import ifetch_miss_unit_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        ifd_cache_miss;
  cache_line_index_t           ifd_cache_miss_paddr;
  local_thread_idx_t           ifd_cache_miss_thread_idx;
  logic                        ifm_request_valid;
  cache_line_index_t           ifm_request_paddr;
  local_thread_idx_t           ifm_request_entry;
  logic                        l2_request_ready;
  logic                        l2_response_valid;
  local_thread_idx_t           l2_response_entry;
  cache_line_data_t            l2_response_data;
  logic                        ifm_lru_fill_en;
  l1i_set_idx_t                ifm_lru_fill_set;
  l1i_way_idx_t                ift_fill_lru;
  logic [L1I_WAYS-1:0]         l2i_itag_update_en;
  l1i_set_idx_t                l2i_itag_update_set;
  l1i_tag_t                    l2i_itag_update_tag;
  logic                        l2i_idata_update_en;
  l1i_way_idx_t                l2i_idata_update_way;
  l1i_set_idx_t                l2i_idata_update_set;
  cache_line_data_t            l2i_idata_update_data;
  logic [THREADS_PER_CORE-1:0] ifm_wake_bitmap;
  logic                        ifm_perf_coalesced;
  logic                        ifm_perf_queue_busy;

  int tests_run    = 0;
  int tests_failed = 0;
  logic perf_on;

  ifetch_miss_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .ifd_cache_miss            (ifd_cache_miss),
    .ifd_cache_miss_paddr      (ifd_cache_miss_paddr),
    .ifd_cache_miss_thread_idx (ifd_cache_miss_thread_idx),
    .ifm_request_valid         (ifm_request_valid),
    .ifm_request_paddr         (ifm_request_paddr),
    .ifm_request_entry         (ifm_request_entry),
    .l2_request_ready          (l2_request_ready),
    .l2_response_valid         (l2_response_valid),
    .l2_response_entry         (l2_response_entry),
    .l2_response_data          (l2_response_data),
    .ifm_lru_fill_en           (ifm_lru_fill_en),
    .ifm_lru_fill_set          (ifm_lru_fill_set),
    .ift_fill_lru              (ift_fill_lru),
    .l2i_itag_update_en        (l2i_itag_update_en),
    .l2i_itag_update_set       (l2i_itag_update_set),
    .l2i_itag_update_tag       (l2i_itag_update_tag),
    .l2i_idata_update_en       (l2i_idata_update_en),
    .l2i_idata_update_way      (l2i_idata_update_way),
    .l2i_idata_update_set      (l2i_idata_update_set),
    .l2i_idata_update_data     (l2i_idata_update_data),
    .ifm_wake_bitmap           (ifm_wake_bitmap),
    .ifm_perf_coalesced        (ifm_perf_coalesced),
    .ifm_perf_queue_busy       (ifm_perf_queue_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifd_cache_miss            = 1'b0;
    ifd_cache_miss_paddr      = '0;
    ifd_cache_miss_thread_idx = '0;
    l2_request_ready          = 1'b0;
    l2_response_valid         = 1'b0;
    l2_response_entry         = '0;
    l2_response_data          = '0;
    ift_fill_lru              = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic miss(input local_thread_idx_t t, input cache_line_index_t a);
    ifd_cache_miss            = 1'b1;
    ifd_cache_miss_thread_idx = t;
    ifd_cache_miss_paddr      = a;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (ifm_request_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_req_valid: got %b want 0", ifm_request_valid);
    end
    tests_run++;
    if ({l2i_itag_update_en, l2i_idata_update_en, ifm_wake_bitmap, ifm_lru_fill_en} !== '0) begin
      tests_failed++; $display("FAIL reset_strobes: got %b/%b/%b/%b want 0", l2i_itag_update_en,
                               l2i_idata_update_en, ifm_wake_bitmap, ifm_lru_fill_en);
    end
    tests_run++;
    if (l2i_idata_update_data !== '0 || ifm_request_paddr !== '0) begin
      tests_failed++; $display("FAIL reset_buses: data nonzero or paddr %h want 0", ifm_request_paddr);
    end
  endtask

  task automatic test_single_fill();
    cache_line_data_t d = {16{32'hA5A5_0001}};
    do_reset();
    miss(2'd1, 26'h1234);
    step();
    ifd_cache_miss = 1'b0;
    #1;
    tests_run++;
    if ({ifm_request_valid, ifm_request_entry, ifm_request_paddr} !== {1'b1, 2'd1, 26'h1234}) begin
      tests_failed++; $display("FAIL single_req: got v%b e%0d a%h want v1 e1 a1234",
                               ifm_request_valid, ifm_request_entry, ifm_request_paddr);
    end
    l2_request_ready = 1'b1;
    step();
    l2_request_ready = 1'b0;
    tests_run++;
    if (ifm_request_valid !== 1'b0) begin
      tests_failed++; $display("FAIL single_req_drop: got %b want 0", ifm_request_valid);
    end
    l2_response_valid = 1'b1; l2_response_entry = 2'd1; l2_response_data = d;
    #1;
    tests_run++;
    if ({ifm_lru_fill_en, ifm_lru_fill_set} !== {1'b1, 6'h34}) begin
      tests_failed++; $display("FAIL single_lru: got en%b set%h want en1 set34", ifm_lru_fill_en, ifm_lru_fill_set);
    end
    step();
    l2_response_valid = 1'b0; ift_fill_lru = 2'd2;
    #1;
    tests_run++;
    if ({l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag, l2i_idata_update_en} !==
        {4'b0100, 6'h34, 20'h48, 1'b0}) begin
      tests_failed++; $display("FAIL single_tag: got en%b set%h tag%h den%b want 0100 34 48 0",
                               l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag, l2i_idata_update_en);
    end
    step();
    tests_run++;
    if ({l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap} !==
        {1'b1, 2'd2, 6'h34, 4'b0010} || l2i_idata_update_data !== d || l2i_itag_update_en !== '0) begin
      tests_failed++; $display("FAIL single_data: got en%b way%0d set%h wake%b tag_en%b want 1 2 34 0010 0000",
                               l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set,
                               ifm_wake_bitmap, l2i_itag_update_en);
    end
    step();
    tests_run++;
    if ({l2i_idata_update_en, ifm_wake_bitmap} !== 5'b0) begin
      tests_failed++; $display("FAIL single_wake_pulse: got en%b wake%b want 0 0000", l2i_idata_update_en, ifm_wake_bitmap);
    end
  endtask

  task automatic test_coalesce();
    int pulses = 0;
    do_reset();
    miss(2'd0, 26'h40);
    #1;
    if (ifm_perf_coalesced === 1'b1) pulses++;
    step();
    miss(2'd2, 26'h40);
    #1;
    if (ifm_perf_coalesced === 1'b1) pulses++;
    step();
    ifd_cache_miss = 1'b0;
    #1;
    tests_run++;
    if (pulses !== (perf_on ? 1 : 0)) begin
      tests_failed++; $display("FAIL coalesce_perf: got %0d pulses want %0d", pulses, perf_on ? 1 : 0);
    end
    tests_run++;
    if ({ifm_request_valid, ifm_request_entry, ifm_request_paddr} !== {1'b1, 2'd0, 26'h40}) begin
      tests_failed++; $display("FAIL coalesce_req: got v%b e%0d a%h want v1 e0 a40",
                               ifm_request_valid, ifm_request_entry, ifm_request_paddr);
    end
    l2_request_ready = 1'b1;
    step();
    tests_run++;
    if (ifm_request_valid !== 1'b0) begin
      tests_failed++; $display("FAIL coalesce_one_req: got %b want 0", ifm_request_valid);
    end
    l2_request_ready = 1'b0;
    l2_response_valid = 1'b1; l2_response_entry = 2'd0; l2_response_data = {16{32'h0000_0040}};
    step();
    l2_response_valid = 1'b0; ift_fill_lru = 2'd1;
    step();
    tests_run++;
    if ({l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap} !==
        {1'b1, 2'd1, 6'h00, 4'b0101}) begin
      tests_failed++; $display("FAIL coalesce_wake: got en%b way%0d set%h wake%b want 1 1 00 0101",
                               l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap);
    end
  endtask

  task automatic test_round_robin();
    local_thread_idx_t exp_e [3] = '{2'd0, 2'd1, 2'd3};
    cache_line_index_t exp_a [3] = '{26'h100, 26'h200, 26'h300};
    do_reset();
    miss(2'd0, 26'h100); step();
    miss(2'd1, 26'h200); step();
    miss(2'd3, 26'h300); step();
    ifd_cache_miss = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if ({ifm_request_valid, ifm_request_entry, ifm_request_paddr} !== {1'b1, 2'd0, 26'h100}) begin
        tests_failed++; $display("FAIL rr_hold cycle %0d: got v%b e%0d a%h want v1 e0 a100", c,
                                 ifm_request_valid, ifm_request_entry, ifm_request_paddr);
      end
      step();
    end
    tests_run++;
    if (ifm_perf_queue_busy !== perf_on) begin
      tests_failed++; $display("FAIL rr_queue_busy: got %b want %b", ifm_perf_queue_busy, perf_on);
    end
    l2_request_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      #1;
      tests_run++;
      if ({ifm_request_valid, ifm_request_entry, ifm_request_paddr} !== {1'b1, exp_e[g], exp_a[g]}) begin
        tests_failed++; $display("FAIL rr_grant %0d: got v%b e%0d a%h want v1 e%0d a%h", g,
                                 ifm_request_valid, ifm_request_entry, ifm_request_paddr, exp_e[g], exp_a[g]);
      end
      step();
    end
    l2_request_ready = 1'b0;
    tests_run++;
    if (ifm_request_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rr_drain: got %b want 0", ifm_request_valid);
    end
  endtask

  task automatic test_r0_merge();
    do_reset();
    miss(2'd2, 26'h80); step();
    ifd_cache_miss = 1'b0; l2_request_ready = 1'b1; step();
    l2_request_ready = 1'b0;
    l2_response_valid = 1'b1; l2_response_entry = 2'd2; l2_response_data = {16{32'h0000_0080}};
    miss(2'd3, 26'h80);
    #1;
    tests_run++;
    if (ifm_perf_coalesced !== perf_on) begin
      tests_failed++; $display("FAIL r0_perf: got %b want %b", ifm_perf_coalesced, perf_on);
    end
    step();
    l2_response_valid = 1'b0; ifd_cache_miss = 1'b0; ift_fill_lru = 2'd3;
    #1;
    tests_run++;
    if (ifm_request_valid !== 1'b0) begin
      tests_failed++; $display("FAIL r0_no_req: got %b want 0", ifm_request_valid);
    end
    step();
    tests_run++;
    if ({l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap} !==
        {1'b1, 2'd3, 6'h00, 4'b1100}) begin
      tests_failed++; $display("FAIL r0_wake: got en%b way%0d set%h wake%b want 1 3 00 1100",
                               l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap);
    end
    step();
    tests_run++;
    if (ifm_request_valid !== 1'b0) begin
      tests_failed++; $display("FAIL r0_no_alloc: got %b want 0", ifm_request_valid);
    end
  endtask

  task automatic test_back_to_back();
    cache_line_data_t da = {16{32'hDA7A_000A}};
    cache_line_data_t db = {16{32'hDA7A_000B}};
    do_reset();
    miss(2'd0, 26'h500); step();
    miss(2'd1, 26'h641); step();
    ifd_cache_miss = 1'b0; l2_request_ready = 1'b1;
    step(); step();
    l2_request_ready = 1'b0;
    l2_response_valid = 1'b1; l2_response_entry = 2'd0; l2_response_data = da;
    miss(2'd2, 26'h700);
    step();
    ifd_cache_miss = 1'b0;
    l2_response_entry = 2'd1; l2_response_data = db; ift_fill_lru = 2'd1;
    #1;
    tests_run++;
    if ({l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag} !== {4'b0010, 6'h00, 20'h14}) begin
      tests_failed++; $display("FAIL b2b_tag0: got en%b set%h tag%h want 0010 00 14",
                               l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag);
    end
    tests_run++;
    if ({ifm_request_valid, ifm_request_entry, ifm_request_paddr} !== {1'b1, 2'd2, 26'h700}) begin
      tests_failed++; $display("FAIL b2b_same_cycle_miss: got v%b e%0d a%h want v1 e2 a700",
                               ifm_request_valid, ifm_request_entry, ifm_request_paddr);
    end
    step();
    l2_response_valid = 1'b0; ift_fill_lru = 2'd3;
    #1;
    tests_run++;
    if ({l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag} !== {4'b1000, 6'h01, 20'h19}) begin
      tests_failed++; $display("FAIL b2b_tag1: got en%b set%h tag%h want 1000 01 19",
                               l2i_itag_update_en, l2i_itag_update_set, l2i_itag_update_tag);
    end
    tests_run++;
    if ({l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap} !==
        {1'b1, 2'd1, 6'h00, 4'b0001} || l2i_idata_update_data !== da) begin
      tests_failed++; $display("FAIL b2b_data0: got en%b way%0d set%h wake%b want 1 1 00 0001 (data A)",
                               l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap);
    end
    step();
    tests_run++;
    if ({l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap} !==
        {1'b1, 2'd3, 6'h01, 4'b0010} || l2i_idata_update_data !== db) begin
      tests_failed++; $display("FAIL b2b_data1: got en%b way%0d set%h wake%b want 1 3 01 0010 (data B)",
                               l2i_idata_update_en, l2i_idata_update_way, l2i_idata_update_set, ifm_wake_bitmap);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    miss(2'd1, 26'h900); step();
    miss(2'd2, 26'hA00); step();
    ifd_cache_miss = 1'b0; l2_request_ready = 1'b1; step();
    l2_request_ready = 1'b0;
    l2_response_valid = 1'b1; l2_response_entry = 2'd1; l2_response_data = {16{32'h0000_0900}};
    step();
    l2_response_valid = 1'b0; ift_fill_lru = 2'd2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if ({l2i_idata_update_en, ifm_wake_bitmap, ifm_request_valid} !== 6'b0) begin
      tests_failed++; $display("FAIL rst_mid_fill: got den%b wake%b req%b want 0 0000 0",
                               l2i_idata_update_en, ifm_wake_bitmap, ifm_request_valid);
    end
    step();
    tests_run++;
    if ({l2i_idata_update_en, ifm_wake_bitmap, ifm_request_valid, l2i_itag_update_en} !== 10'b0) begin
      tests_failed++; $display("FAIL rst_mid_fill_after: got den%b wake%b req%b tag%b want all 0",
                               l2i_idata_update_en, ifm_wake_bitmap, ifm_request_valid, l2i_itag_update_en);
    end
  endtask

  initial begin
`ifdef IFETCH_MISS_PERF_EN
    perf_on = 1'b1;
`else
    perf_on = 1'b0;
`endif
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_fill();
    test_coalesce();
    test_round_robin();
    test_r0_merge();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
